// File: rtl/gpu_types_pkg.sv
// rtl/gpu_types_pkg.sv - warp-control request structs, barrier entry type and reset constants
package gpu_types;

    localparam int GPU_NUM_WARPS    = 4;
    localparam int GPU_NUM_THREADS  = 4;
    localparam int GPU_NUM_BARRIERS = 4;
    localparam int GPU_NW_BITS      = $clog2(GPU_NUM_WARPS);
    localparam int GPU_NB_BITS      = $clog2(GPU_NUM_BARRIERS);

    localparam logic [GPU_NUM_THREADS-1:0] WCTL_RESET_TMASK = 1;

    typedef struct packed {
        logic                       valid;
        logic [GPU_NUM_THREADS-1:0] tmask;
    } gpu_tmc_t;

    typedef struct packed {
        logic                     valid;
        logic [GPU_NUM_WARPS-1:0] wmask;
        logic [31:0]              pc;
    } gpu_wspawn_t;

    typedef struct packed {
        logic                   valid;
        logic [GPU_NB_BITS-1:0] id;
        logic [GPU_NW_BITS-1:0] size_m1;
    } gpu_barrier_t;

    typedef struct packed {
        logic                       valid;
        logic                       diverged;
        logic [GPU_NUM_THREADS-1:0] then_tmask;
    } gpu_split_t;

    typedef struct packed {
        logic [GPU_NW_BITS-1:0]   count;
        logic [GPU_NUM_WARPS-1:0] mask;
    } wctl_bar_entry_t;

endpackage

// File: rtl/vx_warp_ctl_unit_barrier.sv
// rtl/vx_warp_ctl_unit_barrier.sv - vx_barrier_table: per-ID arrival count and waiting mask
module vx_barrier_table
    import gpu_types::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     valid_i,
    input  gpu_barrier_t             req_i,
    input  logic [GPU_NW_BITS-1:0]   wid_i,
    output logic [GPU_NUM_WARPS-1:0] release_mask_o,
    output logic [GPU_NUM_WARPS-1:0] stall_set_o
);

    localparam logic [GPU_NW_BITS-1:0] COUNT_ONE = 1;

    wctl_bar_entry_t [GPU_NUM_BARRIERS-1:0] entry_q, entry_d;

    always_comb begin
        entry_d        = entry_q;
        release_mask_o = '0;
        stall_set_o    = '0;
        if (valid_i && req_i.valid) begin
            // The last arriver releases everyone already waiting and never stalls itself.
            if (entry_q[req_i.id].count == req_i.size_m1) begin
                release_mask_o    = entry_q[req_i.id].mask;
                entry_d[req_i.id] = '0;
            end else begin
                entry_d[req_i.id].mask[wid_i] = 1'b1;
                entry_d[req_i.id].count       = entry_q[req_i.id].count + COUNT_ONE;
                stall_set_o[wid_i]            = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/vx_warp_ctl_unit.sv
// rtl/vx_warp_ctl_unit.sv - warp-control receiver: active/thread masks, barriers, spawn pulse
// Barrier table and stall tracking only exist when WCTL_BARRIER_EN is defined.
module vx_warp_ctl_unit
    import gpu_types::*;
#(
    parameter int NUM_WARPS   = GPU_NUM_WARPS,
    parameter int NUM_THREADS = GPU_NUM_THREADS
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   warp_ctl_valid,
    input  logic [GPU_NW_BITS-1:0]                 warp_ctl_wid,
    input  gpu_tmc_t                               warp_ctl_tmc,
    input  gpu_wspawn_t                            warp_ctl_wspawn,
    input  gpu_barrier_t                           warp_ctl_barrier,
    input  gpu_split_t                             warp_ctl_split,
    output logic [NUM_WARPS-1:0]                   active_warps,
    output logic [NUM_WARPS-1:0]                   stalled_warps,
    output logic [NUM_WARPS-1:0][NUM_THREADS-1:0]  thread_masks,
    output logic                                   spawn_valid,
    output logic [NUM_WARPS-1:0]                   spawn_wmask,
    output logic [31:0]                            spawn_pc
);

    localparam logic [NUM_THREADS-1:0] RESET_TMASK = NUM_THREADS'(WCTL_RESET_TMASK);

    logic [NUM_WARPS-1:0]                  active_q, active_d;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0] tmask_q, tmask_d;
    logic                                  spawn_valid_q, spawn_valid_d;
    logic [NUM_WARPS-1:0]                  spawn_wmask_q, spawn_wmask_d;
    logic [31:0]                           spawn_pc_q, spawn_pc_d;

    logic [NUM_WARPS-1:0] wid_oh;
    logic [NUM_WARPS-1:0] spawn_m;
    logic                 spawn_fire;

    always_comb begin
        active_d             = active_q;
        tmask_d              = tmask_q;
        wid_oh               = '0;
        wid_oh[warp_ctl_wid] = 1'b1;
        spawn_m              = NUM_WARPS'(warp_ctl_wspawn.wmask) & ~wid_oh;
        spawn_fire           = warp_ctl_valid && warp_ctl_wspawn.valid;

        if (warp_ctl_valid) begin
            if (warp_ctl_split.valid && warp_ctl_split.diverged) begin
                tmask_d[warp_ctl_wid] = NUM_THREADS'(warp_ctl_split.then_tmask);
            end
            // tmc is evaluated after split so it overrides a same-cycle divergence.
            if (warp_ctl_tmc.valid) begin
                if (warp_ctl_tmc.tmask != '0) begin
                    tmask_d[warp_ctl_wid] = NUM_THREADS'(warp_ctl_tmc.tmask);
                end else begin
                    active_d[warp_ctl_wid] = 1'b0;
                end
            end
        end

        // spawn_m excludes wid, so this never fights the tmc update above.
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (spawn_fire && spawn_m[w]) begin
                active_d[w] = 1'b1;
                tmask_d[w]  = RESET_TMASK;
            end
        end

        spawn_valid_d = spawn_fire;
        spawn_wmask_d = spawn_fire ? spawn_m : '0;
        spawn_pc_d    = spawn_fire ? warp_ctl_wspawn.pc : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q      <= NUM_WARPS'(1);
            tmask_q       <= '0;
            tmask_q[0]    <= RESET_TMASK;
            spawn_valid_q <= 1'b0;
            spawn_wmask_q <= '0;
            spawn_pc_q    <= '0;
        end else begin
            active_q      <= active_d;
            tmask_q       <= tmask_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_wmask_q <= spawn_wmask_d;
            spawn_pc_q    <= spawn_pc_d;
        end
    end

    assign active_warps = active_q;
    assign thread_masks = tmask_q;
    assign spawn_valid  = spawn_valid_q;
    assign spawn_wmask  = spawn_wmask_q;
    assign spawn_pc     = spawn_pc_q;

`ifdef WCTL_BARRIER_EN
    logic [GPU_NUM_WARPS-1:0] release_mask;
    logic [GPU_NUM_WARPS-1:0] stall_set;
    logic [NUM_WARPS-1:0]     stalled_q, stalled_d;

    vx_barrier_table u_barrier_table (
        .clk            (clk),
        .reset_n        (reset_n),
        .valid_i        (warp_ctl_valid),
        .req_i          (warp_ctl_barrier),
        .wid_i          (warp_ctl_wid),
        .release_mask_o (release_mask),
        .stall_set_o    (stall_set)
    );

    always_comb begin
        stalled_d = (stalled_q & ~NUM_WARPS'(release_mask)) | NUM_WARPS'(stall_set);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stalled_q <= '0;
        end else begin
            stalled_q <= stalled_d;
        end
    end

    assign stalled_warps = stalled_q;
`else
    logic unused_barrier;
    assign unused_barrier = ^warp_ctl_barrier;
    assign stalled_warps  = '0;
`endif

endmodule

// File: tb/tb_vx_warp_ctl_unit.sv
// tb/tb_vx_warp_ctl_unit.sv - directed vector bench for vx_warp_ctl_unit
module tb_vx_warp_ctl_unit;
    import gpu_types::*;

`ifdef WCTL_BARRIER_EN
    localparam bit BAR_EN = 1'b1;
`else
    localparam bit BAR_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               valid;
    logic [1:0]         wid;
    gpu_tmc_t           tmc;
    gpu_wspawn_t        wspawn;
    gpu_barrier_t       barrier;
    gpu_split_t         split;
    logic [3:0]         active_warps;
    logic [3:0]         stalled_warps;
    logic [3:0][3:0]    thread_masks;
    logic               spawn_valid;
    logic [3:0]         spawn_wmask;
    logic [31:0]        spawn_pc;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    vx_warp_ctl_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .warp_ctl_valid   (valid),
        .warp_ctl_wid     (wid),
        .warp_ctl_tmc     (tmc),
        .warp_ctl_wspawn  (wspawn),
        .warp_ctl_barrier (barrier),
        .warp_ctl_split   (split),
        .active_warps     (active_warps),
        .stalled_warps    (stalled_warps),
        .thread_masks     (thread_masks),
        .spawn_valid      (spawn_valid),
        .spawn_wmask      (spawn_wmask),
        .spawn_pc         (spawn_pc)
    );

    typedef struct {
        logic        v;
        logic [1:0]  wid;
        logic        tmc_v;
        logic [3:0]  tmc_m;
        logic        sp_v;
        logic [3:0]  sp_m;
        logic [31:0] pc;
        logic        bar_v;
        logic [1:0]  bar_id;
        logic [1:0]  bar_sz;
        logic        spl_v;
        logic        spl_d;
        logic [3:0]  spl_m;
        logic [3:0]  e_act;
        logic [3:0]  e_stall;
        logic [15:0] e_tm;
        logic        e_sv;
        logic [3:0]  e_swm;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [1:0] w, logic tv, logic [3:0] tm,
                                logic sv, logic [3:0] sm, logic [31:0] pc,
                                logic bv, logic [1:0] bid, logic [1:0] bsz,
                                logic plv, logic pld, logic [3:0] plm,
                                logic [3:0] ea, logic [3:0] es, logic [15:0] etm,
                                logic esv, logic [3:0] eswm, logic [31:0] epc);
        vec_t r;
        r.v = v; r.wid = w; r.tmc_v = tv; r.tmc_m = tm; r.sp_v = sv; r.sp_m = sm; r.pc = pc;
        r.bar_v = bv; r.bar_id = bid; r.bar_sz = bsz; r.spl_v = plv; r.spl_d = pld; r.spl_m = plm;
        r.e_act = ea; r.e_stall = BAR_EN ? es : 4'h0; r.e_tm = etm; r.e_sv = esv;
        r.e_swm = eswm; r.e_pc = epc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; wid = '0; tmc = '0; wspawn = '0; barrier = '0; split = '0;
    endtask

    task automatic drive(input vec_t t);
        valid = t.v; wid = t.wid;
        tmc.valid = t.tmc_v; tmc.tmask = t.tmc_m;
        wspawn.valid = t.sp_v; wspawn.wmask = t.sp_m; wspawn.pc = t.pc;
        barrier.valid = t.bar_v; barrier.id = t.bar_id; barrier.size_m1 = t.bar_sz;
        split.valid = t.spl_v; split.diverged = t.spl_d; split.then_tmask = t.spl_m;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        //                 v wid tv tm   sv sm    pc            bv id sz  plv pld plm   act  stall tm        sv swm  pc
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 32'h0,        0, 0, 0,  0, 0, 4'h0, 4'h1, 4'h0, 16'h0001, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 4'h0, 1, 4'hF, 32'h80000100, 0, 0, 0,  0, 0, 4'h0, 4'hF, 4'h0, 16'h1111, 1, 4'hE, 32'h80000100));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 32'h0,        0, 0, 0,  0, 0, 4'h0, 4'hF, 4'h0, 16'h1111, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 4'hF, 0, 4'h0, 32'h0,        0, 0, 0,  0, 0, 4'h0, 4'hF, 4'h0, 16'h111F, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 4'h0, 0, 4'h0, 32'h0,        0, 0, 0,  0, 0, 4'h0, 4'hE, 4'h0, 16'h111F, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 1, 1, 4'h5, 0, 4'h0, 32'h0,        0, 0, 0,  1, 1, 4'h3, 4'hE, 4'h0, 16'h115F, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 2, 0, 4'h0, 0, 4'h0, 32'h0,        0, 0, 0,  1, 1, 4'h6, 4'hE, 4'h0, 16'h165F, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 3, 0, 4'h0, 0, 4'h0, 32'h0,        0, 0, 0,  1, 0, 4'hF, 4'hE, 4'h0, 16'h165F, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 4'h0, 1, 4'hF, 32'h55,       1, 1, 0,  1, 1, 4'h8, 4'hE, 4'h0, 16'h165F, 0, 4'h0, 32'h0));
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 32'h0,    1, 1, 2,  0, 0, 4'h0, 4'hE, 4'h1, 16'h165F, 0, 4'h0, 32'h0));
            vecs.push_back(mk(1, 1, 0, 4'h0, 0, 4'h0, 32'h0,    1, 1, 2,  0, 0, 4'h0, 4'hE, 4'h3, 16'h165F, 0, 4'h0, 32'h0));
            vecs.push_back(mk(1, 2, 0, 4'h0, 0, 4'h0, 32'h0,    1, 1, 2,  0, 0, 4'h0, 4'hE, 4'h0, 16'h165F, 0, 4'h0, 32'h0));
        end
        vecs.push_back(mk(1, 3, 0, 4'h0, 0, 4'h0, 32'h0,        1, 2, 0,  0, 0, 4'h0, 4'hE, 4'h0, 16'h165F, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 4'h0, 0, 4'h0, 32'h0,        1, 0, 1,  0, 0, 4'h0, 4'hE, 4'h2, 16'h165F, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 2, 0, 4'h0, 0, 4'h0, 32'h0,        1, 3, 1,  0, 0, 4'h0, 4'hE, 4'h6, 16'h165F, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 3, 0, 4'h0, 0, 4'h0, 32'h0,        1, 0, 1,  0, 0, 4'h0, 4'hE, 4'h4, 16'h165F, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 32'h0,        1, 3, 1,  0, 0, 4'h0, 4'hE, 4'h0, 16'h165F, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 2, 1, 4'h0, 1, 4'hF, 32'h1234,     0, 0, 0,  0, 0, 4'h0, 4'hB, 4'h0, 16'h1611, 1, 4'hB, 32'h1234));
        vecs.push_back(mk(1, 0, 0, 4'h0, 1, 4'h1, 32'h40,       0, 0, 0,  0, 0, 4'h0, 4'hB, 4'h0, 16'h1611, 1, 4'h0, 32'h40));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 32'h0,        0, 0, 0,  0, 0, 4'h0, 4'hB, 4'h0, 16'h1611, 0, 4'h0, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d active", i), 32'(active_warps), 32'(vecs[i].e_act));
            chk($sformatf("v%0d stalled", i), 32'(stalled_warps), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d tmasks", i), 32'(thread_masks), 32'(vecs[i].e_tm));
            chk($sformatf("v%0d spawn_valid", i), 32'(spawn_valid), 32'(vecs[i].e_sv));
            if (vecs[i].e_sv) begin
                chk($sformatf("v%0d spawn_wmask", i), 32'(spawn_wmask), 32'(vecs[i].e_swm));
                chk($sformatf("v%0d spawn_pc", i), spawn_pc, vecs[i].e_pc);
            end
        end

        // Async reset with warp0 stalled mid-count and a spawn pulse in flight.
        idle_inputs();
        valid = 1'b1; wid = 2'd0;
        barrier.valid = 1'b1; barrier.id = 2'd0; barrier.size_m1 = 2'd3;
        wspawn.valid = 1'b1; wspawn.wmask = 4'h2; wspawn.pc = 32'h99;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("pre-reset stalled", 32'(stalled_warps), BAR_EN ? 32'h1 : 32'h0);
        chk("pre-reset spawn_valid", 32'(spawn_valid), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset stalled", 32'(stalled_warps), 32'h0);
        chk("async reset spawn_valid", 32'(spawn_valid), 32'h0);
        chk("async reset active", 32'(active_warps), 32'h1);
        chk("async reset tmasks", 32'(thread_masks), 32'h0001);
        @(posedge clk);
        #1 reset_n = 1'b1;

        valid = 1'b1; wid = 2'd0;
        barrier.valid = 1'b1; barrier.id = 2'd0; barrier.size_m1 = 2'd0;
        @(posedge clk);
        #1;
        chk("post-reset size0 stalled", 32'(stalled_warps), 32'h0);
        barrier.size_m1 = 2'd1;
        @(posedge clk);
        #1;
        chk("post-reset count cleared", 32'(stalled_warps), BAR_EN ? 32'h1 : 32'h0);
        wid = 2'd1;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("post-reset release", 32'(stalled_warps), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vx_warp_ctl_unit.md
# VX_warp_ctl_unit

Receiving end of the warp-control channel. Sits in the scheduler stage of the core and consumes `VX_warp_ctl_if.slave` requests from the GPU/SFU execute unit. Holds the authoritative per-warp active mask, per-warp thread masks and barrier state, and drives them to the warp scheduler. Also emits a one-cycle spawn notification so fetch can load spawned-warp PCs.

## Interface
Parameters:
- `NUM_WARPS`, 4, number of hardware warps. `NW_BITS = $clog2(NUM_WARPS)`.
- `NUM_THREADS`, 4, lanes per warp.
- `NUM_BARRIERS`, 4, barrier IDs. `NB_BITS = $clog2(NUM_BARRIERS)`.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `warp_ctl_if`  slave  —  fields used: `valid`, `wid`, `tmc{valid,tmask}`, `wspawn{valid,wmask,pc[31:0]}`, `barrier{valid,id,size_m1}`, `split{valid,diverged,then_tmask}`.
- `active_warps`  out  NUM_WARPS  warp may be scheduled.
- `stalled_warps`  out  NUM_WARPS  warp is waiting at a barrier.
- `thread_masks`  out  NUM_WARPS×NUM_THREADS  per-warp thread mask.
- `spawn_valid`  out  1  one-cycle spawn pulse.
- `spawn_wmask`  out  NUM_WARPS  warps spawned.
- `spawn_pc`  out  32  start PC for spawned warps.

## Operation
- Sub-request valids are sampled only when `valid`=1. There is no backpressure: every request is accepted in the cycle presented.
- Reset values:
  - `active_warps`=1 (warp 0 only).
  - `thread_masks[0]`=1 (lane 0); all other warps' masks 0.
  - `stalled_warps`=0.
  - `spawn_*`=0.
  - All barrier counters and masks 0.
- Split: if `split.valid` and `diverged`, `thread_masks[wid]` ← `then_tmask`. A non-diverged split has no effect here; join is handled by the IPDOM stack, which issues a tmc.
- TMC:
  - Applied after split, so tmc wins on the same warp in the same cycle.
  - `tmask`≠0: `thread_masks[wid]` ← `tmask`; `active_warps` is unchanged.
  - `tmask`=0: `active_warps[wid]` ← 0 and the thread mask is left unchanged.
- Wspawn:
  - Effective mask m = `wmask` & ~(1<<`wid`); the requesting warp is never respawned.
  - For each set bit w of m: `active_warps[w]` ← 1 and `thread_masks[w]` ← 1.
  - Next cycle: `spawn_valid`=1, `spawn_wmask`=m, `spawn_pc`=`pc`. Deasserts after one cycle unless another wspawn arrives.
  - Spawning an already-active warp resets its thread mask to 1.
  - A spawn bit wins over a same-cycle tmc-zero only for a different warp; tmc applies to `wid` only.
- Barrier, per ID: count (NW_BITS) and waiting mask (NUM_WARPS).
  - Arrival with count == `size_m1`: release. `stalled_warps` &= ~mask[id]; mask[id] ← 0; count[id] ← 0. The arriving warp is never stalled.
  - Otherwise: mask[id] |= 1<<`wid`; `stalled_warps[wid]` ← 1; count[id] ← count+1.
  - `size_m1`=0 releases immediately and never stalls.
  - Arrivals on different IDs are independent. Only one arrival per cycle is possible, since there is a single `wid`.
  - A tmc-zero and a barrier arrival from the same warp in one cycle: both apply. The warp ends inactive and stalled; software must not do this.

## Timing
- All outputs are registered. A request presented in cycle N is visible on outputs in cycle N+1.
- `spawn_valid` is a single-cycle pulse in N+1.
- Barrier release clears stall bits in N+1 for all waiting warps simultaneously.
- `reset_n` assertion clears all state immediately, including mid-count barriers and an in-flight spawn pulse. Deassertion is synchronized externally.

## Configuration
- `WCTL_BARRIER_EN` defined: barrier table present, behaviour as above.
- `WCTL_BARRIER_EN` undefined:
  - No counters or masks are instantiated.
  - `barrier` fields are ignored.
  - `stalled_warps` is tied to 0.
  - tmc, split and wspawn behave identically.

## Structure
- `gpu_types` package holds the `gpu_tmc_t`, `gpu_wspawn_t`, `gpu_barrier_t` and `gpu_split_t` request structs.
- Add to `gpu_types`: `wctl_bar_entry_t {count, mask}` and the reset constant `WCTL_RESET_TMASK` = 1.
- One sub-module: `VX_barrier_table`. It holds per-ID entries, takes the arrival request and returns the release mask and stall set. It is instantiated only under `WCTL_BARRIER_EN`.

## Test plan
- Reset, then idle: `active_warps`=0001, `thread_masks[0]`=0001, `stalled_warps`=0000, `spawn_valid`=0.
- tmc wid0 tmask=1111 → `thread_masks[0]`=1111 in the next cycle. Then tmc wid0 tmask=0000 → `active_warps`=0000 and `thread_masks[0]` stays 1111.
- wspawn wid0 wmask=1111 pc=0x8000_0100 → next cycle:
  - `active_warps`=1111 and `thread_masks[1..3]`=0001.
  - `spawn_valid` high exactly one cycle, with `spawn_wmask`=1110 and `spawn_pc`=0x8000_0100.
- Barrier id1 size_m1=2: warp0, then warp1 arrive → `stalled_warps`=0011. Warp2 arrives → `stalled_warps`=0000 next cycle, and warp2 is never stalled. A repeat of the sequence behaves identically.
- Same cycle, wid1: split diverged then_tmask=0011 plus tmc tmask=0101 → `thread_masks[1]`=0101.
- Async reset during a barrier (warp0 stalled on id0, size_m1=3) → `stalled_warps`=0000 immediately. After reset, a barrier on id0 with size_m1=0 releases without stalling.
